// File: rtl/serial_neg_rx.sv
// serial_neg_rx
// Receive-side companion to the serial two's-complement negator. Takes an
// LSB-first bit stream, applies the copy-until-first-1-then-invert rule to
// undo the negation, deserializes each W-bit frame and presents the word on
// a valid/ready output. Framing violations (stray bits in IDLE, resync in
// the middle of a frame) produce a one-cycle sync_err pulse.
//
// Optional feature: define SERIAL_NEG_RX_OVF_EN to add the ovf output, which
// flags a decoded word equal to the most negative value.

module serial_neg_rx #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic         in_bit,
   input  logic         in_first,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         sync_err
`ifdef SERIAL_NEG_RX_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int            CW       = $clog2(W);
   localparam logic [CW-1:0] LAST     = CW'(W - 1);
   localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      COPY,
      INVERT,
      HOLD
   } state_t;

   state_t        state;
   logic [W-1:0]  sr;
   logic [CW-1:0] cnt;
   logic          d_bit;
   logic [W-1:0]  sr_next;

   // Bits are only taken when no word is waiting on the output.
   assign in_ready = (state != HOLD);

   // Decoded bit and shifted word for a normal in-frame bit.
   always_comb begin
      d_bit   = in_bit;
      sr_next = sr;
      if (state == INVERT) begin
         d_bit = ~in_bit;
      end
      sr_next = {d_bit, sr[W-1:1]};
   end

   // Frame state machine, shift register, bit counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sr        <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
`ifdef SERIAL_NEG_RX_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         sync_err <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (in_first) begin
                     sr    <= {in_bit, {(W-1){1'b0}}};
                     cnt   <= CW'(1);
                     state <= in_bit ? INVERT : COPY;
                  end else begin
                     sync_err <= 1'b1;
                  end
               end
            end
            COPY, INVERT: begin
               if (in_valid) begin
                  if (in_first) begin
                     sync_err <= 1'b1;
                     sr       <= {in_bit, {(W-1){1'b0}}};
                     cnt      <= CW'(1);
                     state    <= in_bit ? INVERT : COPY;
                  end else if (cnt == LAST) begin
                     sr        <= sr_next;
                     cnt       <= '0;
                     out_data  <= sr_next;
                     out_valid <= 1'b1;
                     state     <= HOLD;
`ifdef SERIAL_NEG_RX_OVF_EN
                     ovf       <= (sr_next == MOST_NEG);
`endif
                  end else begin
                     sr    <= sr_next;
                     cnt   <= cnt + CW'(1);
                     if (state == COPY && in_bit) begin
                        state <= INVERT;
                     end
                  end
               end
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
`ifdef SERIAL_NEG_RX_OVF_EN
                  ovf       <= 1'b0;
`endif
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef SERIAL_NEG_RX_OVF_EN
   // Without the overflow flag the most-negative constant has no user.
   logic unused_most_neg;
   assign unused_most_neg = ^MOST_NEG;
`endif

endmodule
